// File: rtl/bcdn2bin.sv
// bcdn2bin: multi-digit packed BCD to binary converter (reverse double-dabble).
// One result bit per cycle: {bcd, work} shifts right, BCD digits >= 8 get -3.
// Optional build macro BCDN2BIN_ERRCHK_EN adds an invalid-digit (>9) checker;
// without it err is tied low and invalid digits give an unspecified result.
module bcdn2bin #(
   parameter int unsigned DIGITS = 2,
   parameter int unsigned BIN_W  = 7
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  ready,
   output logic                  done_tick,
   output logic [BIN_W-1:0]      bin,
   output logic                  err
);

   localparam int unsigned BCD_W = 4 * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OP   = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_load;
   logic               w_shift;
   logic               w_finish;

   logic [BCD_W-1:0]   r_bcd;
   logic [BIN_W-1:0]   r_work;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ready;
   logic               r_done;
   logic [BIN_W-1:0]   r_bin;

   logic [BCD_W-1:0]   w_bcd_sh;
   logic [BCD_W-1:0]   w_bcd_cor;
   logic [BIN_W-1:0]   w_work_sh;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and datapath control decode
   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      w_shift  = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_load = 1'b1;
               w_next = S_OP;
            end
         end
         S_OP: begin
            w_shift = 1'b1;
            // Counter holds the number of shifts still to do, including this one
            if (r_cnt <= CNT_W'(1)) begin
               w_finish = 1'b1;
               w_next   = S_DONE;
            end
         end
         S_DONE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Handshake outputs registered from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ready <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_ready <= (w_next == S_IDLE);
         r_done  <= (w_next == S_DONE);
      end
   end

   // One right shift of {bcd, work}, then per-digit -3 correction in parallel
   always_comb begin
      w_work_sh = {r_bcd[0], r_work[BIN_W-1:1]};
      w_bcd_sh  = {1'b0, r_bcd[BCD_W-1:1]};
      w_bcd_cor = w_bcd_sh;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (w_bcd_sh[4*d +: 4] >= 4'd8) begin
            w_bcd_cor[4*d +: 4] = w_bcd_sh[4*d +: 4] - 4'd3;
         end
      end
   end

   // Operand capture, shift/correct iteration and shift counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bcd  <= '0;
         r_work <= '0;
         r_cnt  <= '0;
      end else if (w_load) begin
         r_bcd  <= bcd;
         r_work <= '0;
         r_cnt  <= CNT_W'(BIN_W);
      end else if (w_shift) begin
         r_bcd  <= w_bcd_cor;
         r_work <= w_work_sh;
         r_cnt  <= r_cnt - CNT_W'(1);
      end
   end

`ifdef BCDN2BIN_ERRCHK_EN
   logic w_bad;
   logic r_err_flag;
   logic r_err;

   // Any captured digit above 9 marks the operand invalid
   always_comb begin
      w_bad = 1'b0;
      for (int d = 0; d < int'(DIGITS); d++) begin
         if (bcd[4*d +: 4] > 4'd9) begin
            w_bad = 1'b1;
         end
      end
   end

   // Invalid flag is captured with the operand and travels with the conversion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err_flag <= 1'b0;
      end else if (w_load) begin
         r_err_flag <= w_bad;
      end
   end

   // Result and error update only on the completion edge; invalid forces bin=0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bin <= '0;
         r_err <= 1'b0;
      end else if (w_finish) begin
         r_bin <= r_err_flag ? '0 : w_work_sh;
         r_err <= r_err_flag;
      end
   end

   assign err = r_err;
`else
   // Result updates only on the completion edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bin <= '0;
      end else if (w_finish) begin
         r_bin <= w_work_sh;
      end
   end

   assign err = 1'b0;
`endif

   assign ready     = r_ready;
   assign done_tick = r_done;
   assign bin       = r_bin;

endmodule

// File: tb/tb_bcdn2bin.sv
// Scoreboard bench for bcdn2bin: a 2-digit (BIN_W=7) and a 3-digit (BIN_W=10)
// instance share clock and reset. Expected results and completion cycles are
// queued when a start is driven and checked when done_tick is seen.
module tb_bcdn2bin;

   logic        clk = 1'b0;
   logic        reset_n;

   logic        start2;
   logic [7:0]  bcd2;
   logic        ready2, done2, err2;
   logic [6:0]  bin2;

   logic        start3;
   logic [11:0] bcd3;
   logic        ready3, done3, err3;
   logic [9:0]  bin3;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int n_done2 = 0;

   typedef struct {
      int unsigned bin;
      int unsigned err;
      int          cyc;
   } exp_t;

   exp_t q2[$];
   exp_t q3[$];

   bcdn2bin #(.DIGITS(2), .BIN_W(7)) u_dut2 (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start2),
      .bcd       (bcd2),
      .ready     (ready2),
      .done_tick (done2),
      .bin       (bin2),
      .err       (err2)
   );

   bcdn2bin #(.DIGITS(3), .BIN_W(10)) u_dut3 (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start3),
      .bcd       (bcd3),
      .ready     (ready3),
      .done_tick (done3),
      .bin       (bin3),
      .err       (err3)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  tag, got, got, exp, exp, cyc);
      end
   endtask

   // Scoreboard: pop and compare on every done_tick
   always @(negedge clk) begin
      exp_t e;
      if (reset_n === 1'b1) begin
         if (done2 === 1'b1) begin
            n_done2++;
            if (q2.size() == 0) begin
               check("d2_spurious_done", 1, 0);
            end else begin
               e = q2.pop_front();
               check("d2_bin", 32'(bin2), e.bin);
               check("d2_err", 32'(err2), e.err);
               check("d2_done_cycle", cyc, e.cyc);
            end
         end
         if (done3 === 1'b1) begin
            if (q3.size() == 0) begin
               check("d3_spurious_done", 1, 0);
            end else begin
               e = q3.pop_front();
               check("d3_bin", 32'(bin3), e.bin);
               check("d3_err", 32'(err3), e.err);
               check("d3_done_cycle", cyc, e.cyc);
            end
         end
      end
   end

   task automatic wait_q2();
      for (int i = 0; i < 40 && q2.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      if (q2.size() != 0) begin
         check("d2_timeout", 1, 0);
         q2.delete();
      end
   endtask

   task automatic wait_q3();
      for (int i = 0; i < 40 && q3.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      if (q3.size() != 0) begin
         check("d3_timeout", 1, 0);
         q3.delete();
      end
   endtask

   // Single conversion on the 2-digit instance, with ready handshake checks
   task automatic go2(input logic [7:0] v, input int unsigned eb, input int unsigned ee);
      exp_t e;
      @(negedge clk);
      bcd2   = v;
      start2 = 1'b1;
      e.bin = eb; e.err = ee; e.cyc = cyc + 8;
      q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      check("d2_ready_fall", 32'(ready2), 0);
      wait_q2();
      @(negedge clk);
      check("d2_ready_rise", 32'(ready2), 1);
   endtask

   task automatic go3(input logic [11:0] v, input int unsigned eb);
      exp_t e;
      @(negedge clk);
      bcd3   = v;
      start3 = 1'b1;
      e.bin = eb; e.err = 0; e.cyc = cyc + 11;
      q3.push_back(e);
      @(negedge clk);
      start3 = 1'b0;
      check("d3_ready_fall", 32'(ready3), 0);
      wait_q3();
      @(negedge clk);
      check("d3_ready_rise", 32'(ready3), 1);
   endtask

   initial begin
      exp_t e;
      int   c;
      int   dn;

      reset_n = 1'b0;
      start2  = 1'b0;
      bcd2    = '0;
      start3  = 1'b0;
      bcd3    = '0;
      repeat (3) @(negedge clk);
      check("rst_ready2", 32'(ready2), 1);
      check("rst_done2",  32'(done2),  0);
      check("rst_bin2",   32'(bin2),   0);
      check("rst_err2",   32'(err2),   0);
      check("rst_ready3", 32'(ready3), 1);
      check("rst_bin3",   32'(bin3),   0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic two-digit conversions
      go2(8'h99, 99, 0);
      go2(8'h00, 0, 0);
      go2(8'h47, 47, 0);
      go2(8'h10, 10, 0);
      go2(8'h81, 81, 0);

      // Back-to-back with start held: second operand sampled 9 cycles later
      @(negedge clk);
      c      = cyc;
      bcd2   = 8'h25;
      start2 = 1'b1;
      e.bin = 25; e.err = 0; e.cyc = c + 8;
      q2.push_back(e);
      e.bin = 63; e.err = 0; e.cyc = c + 17;
      q2.push_back(e);
      @(negedge clk);
      bcd2 = 8'h63;
      while (cyc < c + 10) @(negedge clk);
      start2 = 1'b0;
      check("b2b_ready_low", 32'(ready2), 0);
      wait_q2();

      // Starts during OP with a different operand are ignored
      dn = n_done2;
      @(negedge clk);
      bcd2   = 8'h58;
      start2 = 1'b1;
      e.bin = 58; e.err = 0; e.cyc = cyc + 8;
      q2.push_back(e);
      @(negedge clk);
      start2 = 1'b0;
      @(negedge clk);
      bcd2   = 8'h13;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      bcd2   = 8'h77;
      wait_q2();
      repeat (12) @(negedge clk);
      #1;
      check("ignore_one_done", n_done2 - dn, 1);

      // Three-digit instance
      go3(12'h999, 999);
      go3(12'h512, 512);
      go3(12'h000, 0);

`ifdef BCDN2BIN_ERRCHK_EN
      go2(8'h3A, 0, 1);
`endif
      go2(8'h12, 12, 0);

      // Asynchronous reset 3 cycles into OP aborts the conversion
      dn = n_done2;
      @(negedge clk);
      c      = cyc;
      bcd2   = 8'h64;
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      while (cyc < c + 4) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_ready", 32'(ready2), 1);
      check("abort_bin",   32'(bin2),   0);
      check("abort_err",   32'(err2),   0);
      check("abort_done",  32'(done2),  0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (12) @(negedge clk);
      #1;
      check("abort_no_done", n_done2 - dn, 0);
      check("abort_bin_hold", 32'(bin2), 0);

      go2(8'h64, 64, 0);
      go2(8'h99, 99, 0);

      check("queues_empty", 32'(q2.size() + q3.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
